// File: rtl/instr_pkg.sv
// Shared encodings for the MIPS instruction encoder: mnemonic kinds, opcode/funct
// fields, error codes and fixed instruction words.
package instr_pkg;

    typedef enum logic [5:0] {
        K_NOP     = 6'd0,
        K_ADD     = 6'd1,
        K_ADDU    = 6'd2,
        K_SUB     = 6'd3,
        K_SUBU    = 6'd4,
        K_AND     = 6'd5,
        K_OR      = 6'd6,
        K_SLT     = 6'd7,
        K_SLTU    = 6'd8,
        K_MULT    = 6'd9,
        K_MULTU   = 6'd10,
        K_DIV     = 6'd11,
        K_DIVU    = 6'd12,
        K_MFHI    = 6'd13,
        K_MFLO    = 6'd14,
        K_MTHI    = 6'd15,
        K_MTLO    = 6'd16,
        K_JR      = 6'd17,
        K_SYSCALL = 6'd18,
        K_ORI     = 6'd19,
        K_ANDI    = 6'd20,
        K_ADDI    = 6'd21,
        K_ADDIU   = 6'd22,
        K_LUI     = 6'd23,
        K_LW      = 6'd24,
        K_LH      = 6'd25,
        K_LB      = 6'd26,
        K_SW      = 6'd27,
        K_SH      = 6'd28,
        K_SB      = 6'd29,
        K_BEQ     = 6'd30,
        K_BNE     = 6'd31,
        K_JAL     = 6'd32,
        K_MFC0    = 6'd33,
        K_MTC0    = 6'd34,
        K_ERET    = 6'd35,
        K_LI      = 6'd36
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_W0   = 2'd1,
        S_W1   = 2'd2,
        S_DS   = 2'd3
    } state_e;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;

    localparam logic [4:0] C0_MF      = 5'b00000;
    localparam logic [4:0] C0_MT      = 5'b00100;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_KIND   = 2'd1;
    localparam logic [1:0] ERR_ALIGN  = 2'd2;
    localparam logic [1:0] ERR_RANGE  = 2'd3;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;
    localparam logic [31:0] ERET_WORD    = 32'h4200_0018;

    function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt,
                                           logic [4:0] rd, logic [5:0] funct);
        return {OP_SPECIAL, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs,
                                           logic [4:0] rt, logic [15:0] imm16);
        return {op, rs, rt, imm16};
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: turns one mnemonic request into its machine word(s)
// and flags, or reports why the request cannot be encoded.
module instr_field_pack
    import instr_pkg::*;
(
    input  logic [5:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] word,
    output logic [31:0] word1,
    output logic        needs_w1,
    output logic        is_cti,
    output logic        err,
    output logic [1:0]  err_code
);

    logic [31:0] br_off;
    logic        br_misaligned;
    logic        br_out_of_range;

    // Offset is relative to the slot after the branch, in words.
    assign br_off          = $signed(imm - (pc + 32'd4)) >>> 2;
    assign br_misaligned   = (imm[1:0] != 2'b00);
    assign br_out_of_range = !((&br_off[31:15]) || !(|br_off[31:15]));

    always_comb begin
        word     = NOP_WORD;
        word1    = NOP_WORD;
        needs_w1 = 1'b0;
        is_cti   = 1'b0;
        err      = 1'b0;
        err_code = ERR_NONE;
        case (kind_e'(kind))
            K_NOP:     word = NOP_WORD;
            K_ADD:     word = r_word(rs, rt, rd, FN_ADD);
            K_ADDU:    word = r_word(rs, rt, rd, FN_ADDU);
            K_SUB:     word = r_word(rs, rt, rd, FN_SUB);
            K_SUBU:    word = r_word(rs, rt, rd, FN_SUBU);
            K_AND:     word = r_word(rs, rt, rd, FN_AND);
            K_OR:      word = r_word(rs, rt, rd, FN_OR);
            K_SLT:     word = r_word(rs, rt, rd, FN_SLT);
            K_SLTU:    word = r_word(rs, rt, rd, FN_SLTU);
            K_MULT:    word = r_word(rs, rt, 5'd0, FN_MULT);
            K_MULTU:   word = r_word(rs, rt, 5'd0, FN_MULTU);
            K_DIV:     word = r_word(rs, rt, 5'd0, FN_DIV);
            K_DIVU:    word = r_word(rs, rt, 5'd0, FN_DIVU);
            K_MFHI:    word = r_word(5'd0, 5'd0, rd, FN_MFHI);
            K_MFLO:    word = r_word(5'd0, 5'd0, rd, FN_MFLO);
            K_MTHI:    word = r_word(rs, 5'd0, 5'd0, FN_MTHI);
            K_MTLO:    word = r_word(rs, 5'd0, 5'd0, FN_MTLO);
            K_JR: begin
                word   = r_word(rs, 5'd0, 5'd0, FN_JR);
                is_cti = 1'b1;
            end
            K_SYSCALL: word = SYSCALL_WORD;
            K_ORI:     word = i_word(OP_ORI,   rs, rt, imm[15:0]);
            K_ANDI:    word = i_word(OP_ANDI,  rs, rt, imm[15:0]);
            K_ADDI:    word = i_word(OP_ADDI,  rs, rt, imm[15:0]);
            K_ADDIU:   word = i_word(OP_ADDIU, rs, rt, imm[15:0]);
            K_LUI:     word = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
            K_LW:      word = i_word(OP_LW, rs, rt, imm[15:0]);
            K_LH:      word = i_word(OP_LH, rs, rt, imm[15:0]);
            K_LB:      word = i_word(OP_LB, rs, rt, imm[15:0]);
            K_SW:      word = i_word(OP_SW, rs, rt, imm[15:0]);
            K_SH:      word = i_word(OP_SH, rs, rt, imm[15:0]);
            K_SB:      word = i_word(OP_SB, rs, rt, imm[15:0]);
            K_BEQ, K_BNE: begin
                is_cti = 1'b1;
                if (br_misaligned) begin
                    err      = 1'b1;
                    err_code = ERR_ALIGN;
                end else if (br_out_of_range) begin
                    err      = 1'b1;
                    err_code = ERR_RANGE;
                end else begin
                    word = i_word((kind_e'(kind) == K_BEQ) ? OP_BEQ : OP_BNE,
                                  rs, rt, br_off[15:0]);
                end
            end
            K_JAL: begin
                is_cti = 1'b1;
                if (br_misaligned) begin
                    err      = 1'b1;
                    err_code = ERR_ALIGN;
                end else begin
                    word = {OP_JAL, imm[27:2]};
                end
            end
            K_MFC0:    word = {OP_COP0, C0_MF, rt, rd, 11'd0};
            K_MTC0:    word = {OP_COP0, C0_MT, rt, rd, 11'd0};
            K_ERET:    word = ERET_WORD;
            K_LI: begin
                // A zero upper half fits in one ori from $0.
                if (imm[31:16] != 16'd0) begin
                    word     = i_word(OP_LUI, 5'd0, rt, imm[31:16]);
                    word1    = i_word(OP_ORI, rt, rt, imm[15:0]);
                    needs_w1 = 1'b1;
                end else begin
                    word = i_word(OP_ORI, 5'd0, rt, imm[15:0]);
                end
            end
            default: begin
                err      = 1'b1;
                err_code = ERR_KIND;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential MIPS encoder: accepts one request at a time, emits its word(s)
// tagged with a running PC, expanding li and appending delay-slot nops.
module instr_encoder
    import instr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter bit          AUTO_NOP  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_err,
    output logic [1:0]  err_code,
    output logic [15:0] word_count
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] word1_q, word1_d;
    logic        needs_w1_q, needs_w1_d;
    logic        is_cti_q, is_cti_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] count_q, count_d;

    logic [31:0] pk_word, pk_word1;
    logic        pk_needs_w1, pk_is_cti, pk_err;
    logic [1:0]  pk_err_code;
    logic        accept, handshake;

    instr_field_pack u_pack (
        .kind     (in_kind),
        .rs       (in_rs),
        .rt       (in_rt),
        .rd       (in_rd),
        .imm      (in_imm),
        .pc       (pc_q),
        .word     (pk_word),
        .word1    (pk_word1),
        .needs_w1 (pk_needs_w1),
        .is_cti   (pk_is_cti),
        .err      (pk_err),
        .err_code (pk_err_code)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && !pk_err) state_d = S_W0;
            S_W0: begin
                if (handshake) begin
                    if (needs_w1_q)                state_d = S_W1;
                    else if (is_cti_q && AUTO_NOP) state_d = S_DS;
                    else                           state_d = S_IDLE;
                end
            end
            S_W1, S_DS: if (handshake) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q != S_IDLE);
        out_instr  = instr_q;
        out_pc     = pc_q;
        out_err    = err_q;
        err_code   = err_code_q;
        word_count = count_q;
    end

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // Rejected requests are consumed but leave the PC and word stream untouched.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        word1_d    = word1_q;
        needs_w1_d = needs_w1_q;
        is_cti_d   = is_cti_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        count_d    = count_q;
        if (accept) begin
            if (pk_err) begin
                err_d      = 1'b1;
                err_code_d = pk_err_code;
            end else begin
                instr_d    = pk_word;
                word1_d    = pk_word1;
                needs_w1_d = pk_needs_w1;
                is_cti_d   = pk_is_cti;
            end
        end
        if (handshake) begin
            pc_d    = pc_q + 32'd4;
            count_d = count_q + 16'd1;
            if (state_q == S_W0) begin
                if (needs_w1_q)                instr_d = word1_q;
                else if (is_cti_q && AUTO_NOP) instr_d = NOP_WORD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= BASE_ADDR;
            instr_q    <= NOP_WORD;
            word1_q    <= NOP_WORD;
            needs_w1_q <= 1'b0;
            is_cti_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            count_q    <= 16'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            word1_q    <= word1_d;
            needs_w1_q <= needs_w1_d;
            is_cti_q   <= is_cti_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push expected words/errors,
// a negedge monitor pops and compares whatever the encoder presents.
module tb_instr_encoder;
    import instr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_kind = 6'd0;
    logic [4:0]  in_rs = 5'd0;
    logic [4:0]  in_rt = 5'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_err;
    logic [1:0]  err_code;
    logic [15:0] word_count;

    instr_encoder #(.BASE_ADDR(32'h0000_3000), .AUTO_NOP(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_err    (out_err),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        word_q[$];
    logic [1:0]  err_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc = 32'h0000_3000;
    exp_t        mon_e;
    logic [1:0]  mon_c;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s", name);
    endtask

    task automatic pushWord(input logic [31:0] w);
        exp_t e;
        e.instr = w;
        e.pc    = exp_pc;
        word_q.push_back(e);
        exp_pc += 32'd4;
    endtask

    task automatic pushErr(input logic [1:0] c);
        err_q.push_back(c);
    endtask

    task automatic applyStimulus(input logic [5:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [31:0] imm);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            failNow("in_ready timeout");
            return;
        end
        in_kind  = k;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((word_q.size() != 0 || err_q.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) failNow("drain timeout");
    endtask

    task automatic resetDut();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp_pc = 32'h0000_3000;
    endtask

    // Monitor: every presented word or error pulse must match the head of its queue.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (word_q.size() == 0) begin
                    failNow("unexpected word");
                end else begin
                    mon_e = word_q.pop_front();
                    checkOutput("word", out_instr, mon_e.instr);
                    checkOutput("pc", out_pc, mon_e.pc);
                end
            end
            if (out_err) begin
                if (err_q.size() == 0) begin
                    failNow("unexpected err");
                end else begin
                    mon_c = err_q.pop_front();
                    checkOutput("err_code", {30'd0, err_code}, {30'd0, mon_c});
                    checkOutput("err_no_word", {31'd0, out_valid}, 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        resetDut();
        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        checkOutput("rst_out_pc", out_pc, 32'h0000_3000);
        checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
        checkOutput("rst_err_code", {30'd0, err_code}, 32'd0);
        checkOutput("rst_word_count", {16'd0, word_count}, 32'd0);

        pushWord(32'h0022_1821);
        applyStimulus(K_ADDU, 5'd1, 5'd2, 5'd3, 32'd0);
        waitDrain();
        checkOutput("addu_count", {16'd0, word_count}, 32'd1);
        checkOutput("addu_idle", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b0;
        pushWord(32'h3402_1234);
        applyStimulus(K_ORI, 5'd0, 5'd2, 5'd0, 32'h0000_1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_instr", out_instr, 32'h3402_1234);
            checkOutput("hold_pc", out_pc, 32'h0000_3004);
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        waitDrain();

        pushWord(32'h3C08_1234);
        pushWord(32'h3508_5678);
        applyStimulus(K_LI, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
        waitDrain();
        pushWord(32'h3408_0042);
        applyStimulus(K_LI, 5'd0, 5'd8, 5'd0, 32'h0000_0042);
        waitDrain();
        pushWord(ERET_WORD);
        applyStimulus(K_ERET, 5'd0, 5'd0, 5'd0, 32'd0);
        pushWord(32'h0000_000C);
        applyStimulus(K_SYSCALL, 5'd0, 5'd0, 5'd0, 32'd0);
        pushWord(32'hAFA5_FFFC);
        applyStimulus(K_SW, 5'd29, 5'd5, 5'd0, 32'h0000_FFFC);
        pushWord(32'h4003_6000);
        applyStimulus(K_MFC0, 5'd0, 5'd3, 5'd12, 32'd0);
        waitDrain();

        resetDut();
        @(negedge clk);
        checkOutput("rst2_word_count", {16'd0, word_count}, 32'd0);

        pushWord(32'h1022_0001);
        pushWord(32'h0000_0000);
        applyStimulus(K_BEQ, 5'd1, 5'd2, 5'd0, 32'h0000_3008);
        waitDrain();
        pushWord(32'h0C00_0C04);
        pushWord(32'h0000_0000);
        applyStimulus(K_JAL, 5'd0, 5'd0, 5'd0, 32'h0000_3010);
        waitDrain();
        pushWord(32'h1000_FFFF);
        pushWord(32'h0000_0000);
        applyStimulus(K_BEQ, 5'd0, 5'd0, 5'd0, 32'h0000_3010);
        waitDrain();

        pushErr(2'd1);
        applyStimulus(6'd63, 5'd0, 5'd0, 5'd0, 32'd0);
        waitDrain();
        pushErr(2'd2);
        applyStimulus(K_BEQ, 5'd1, 5'd2, 5'd0, 32'h0000_3006);
        waitDrain();
        pushErr(2'd3);
        applyStimulus(K_BEQ, 5'd1, 5'd2, 5'd0, 32'h0004_3000);
        waitDrain();
        @(negedge clk);
        checkOutput("err_sticky", {30'd0, err_code}, 32'd3);
        checkOutput("err_pulse_end", {31'd0, out_err}, 32'd0);
        checkOutput("err_pc_kept", out_pc, 32'h0000_3018);

        pushWord(32'h00A6_2022);
        applyStimulus(K_SUB, 5'd5, 5'd6, 5'd4, 32'd0);
        waitDrain();

        pushWord(32'h3C08_1234);
        applyStimulus(K_LI, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("w1_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("w1_instr", out_instr, 32'h3508_5678);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        exp_pc = 32'h0000_3000;
        @(negedge clk);
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_pc", out_pc, 32'h0000_3000);
        checkOutput("midrst_count", {16'd0, word_count}, 32'd0);
        checkOutput("midrst_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        pushWord(32'h0022_1821);
        applyStimulus(K_ADDU, 5'd1, 5'd2, 5'd3, 32'd0);
        waitDrain();
        checkOutput("post_rst_count", {16'd0, word_count}, 32'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential MIPS instruction encoder. It is the inverse of the pipeline's instruction decoder.
- Accepts a mnemonic code plus operand fields over a valid/ready handshake and emits 32-bit machine words, each tagged with its PC.
- Expands the li pseudo-instruction and optionally appends a delay-slot nop after control transfers.
- Feeds the IM loader and the bench-side program generator for the P7 CPU.

Parameters:
- BASE_ADDR, 32'h0000_3000, PC of the first emitted word.
- AUTO_NOP, 1, 1 = append 0x00000000 after beq/bne/jal/jr.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk)
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept a request
- in_kind  in  6  mnemonic code (instr_pkg)
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field
- in_imm  in  32  immediate; for branch/jal, the target byte address
- out_valid  out  1  word present
- out_ready  in  1  sink accepts word
- out_instr  out  32  encoded word
- out_pc  out  32  PC of out_instr
- out_err  out  1  one-cycle pulse on a rejected request
- err_code  out  2  1 = unknown kind, 2 = misaligned target, 3 = branch out of range
- word_count  out  16  words emitted since reset

Behaviour:
- Reset values: state IDLE, out_valid=0, out_instr=0, out_pc=BASE_ADDR, out_err=0, err_code=0, word_count=0, in_ready=1.
- Reset mid-sequence: pending and expansion words are discarded.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - W0: first word.
  - W1: li low half.
  - DS: delay-slot nop.
- Accept: in_valid&&in_ready in cycle N. Fields are latched, and out_valid=1 with the first word in cycle N+1 (latency 1). in_ready=0 outside IDLE.
- Output hold: out_instr and out_pc stay stable while out_valid&&!out_ready.
- Each out_valid&&out_ready handshake: PC += 4, word_count += 1 (wraps at 16 bits).
- W0 transitions on handshake:
  - li with in_imm[31:16]!=0 -> W1.
  - beq/bne/jal/jr with AUTO_NOP=1 -> DS.
  - otherwise -> IDLE.
- W1 and DS transition to IDLE on handshake.
- Supported kinds:
  - R-type: add, addu, sub, subu, and, or, slt, sltu.
  - mult, multu, div, divu.
  - mfhi, mflo, mthi, mtlo.
  - jr, syscall (0x0000000C), nop (0).
  - I-type: ori, andi, addi, addiu, lui (rs=0), lw, lh, lb, sw, sh, sb.
  - beq, bne, jal.
  - mfc0 (op 010000, field 00000, rt, rd), mtc0 (field 00100), eret (0x42000018).
  - li.
- Encoding rules:
  - R-type: shamt=0.
  - mult/div: rd=0.
  - mfhi/mflo: rd only.
  - mthi/mtlo/jr: rs only.
- li expansion:
  - Upper half nonzero: lui rt,imm[31:16] then ori rt,rt,imm[15:0].
  - Upper half zero: single ori rt,$0,imm[15:0].
- Branch offset: off=(in_imm-(pc+4))>>>2, where pc is the PC the branch will occupy. Error 3 if off is not within [-32768, 32767]. Error 2 if in_imm[1:0]!=0.
- jal: imm26=in_imm[27:2]. Error 2 if misaligned. in_imm[31:28] is not checked.
- Error handling: out_err pulses in cycle N+1 with err_code set. No word is emitted, PC is unchanged, and the request counts as consumed (state stays IDLE).
- err_code holds its value until the next error or reset.
- in_valid while in_ready=0 is ignored; the requester must hold it.

Decomposition:
- instr_pkg holds:
  - kind enum (6-bit codes, including K_LI);
  - opcode/funct constants: OP_SPECIAL=000000, OP_COP0=010000, FN_ADD=100000, etc.;
  - ERR_* codes;
  - NOP and ERET words.
- One combinational sub-module, instr_field_pack: kind, fields, pc -> word, second word, needs_w1, is_cti, err, err_code.
- The FSM, PC counter and handshake stay in instr_encoder.

Test Plan:
- addu rd=3, rs=1, rt=2 -> 0x00221821 at pc 0x3000. word_count becomes 1. Returns to IDLE.
- ori rt=2, rs=0, imm=0x1234 -> 0x34021234. Hold out_ready=0 for 3 cycles -> word and pc held stable, in_ready=0.
- li rt=8, imm=0x12345678 -> 0x3C081234 @0x3000, then 0x35085678 @0x3004. li imm=0x00000042 -> single 0x34080042.
- beq rs=1, rt=2 at pc 0x3000, target 0x3008 -> 0x10220001, then nop 0x00000000 @0x3004 (AUTO_NOP=1). jal target 0x3010 -> 0x0C000C04.
- Error cases, each with no word emitted and pc unchanged:
  - unknown kind -> out_err=1, err_code=1;
  - beq target 0x3006 -> err_code=2;
  - beq target 0x3000+0x40000 -> err_code=3.
- Reset asserted (reset=0) while in W1 of li -> next cycle out_valid=0, pc=0x3000, word_count=0; first post-reset request encodes correctly.
